// File: rtl/divider_if.sv
// Handshake and result bundle for the sequential divider.
// The controller drives start/a/b and the divider drives everything else.
interface divider_if #(
    parameter int WIDTH = 8
);
    logic                    start;
    logic signed [WIDTH-1:0] a;
    logic signed [WIDTH-1:0] b;
    logic signed [WIDTH-1:0] quot;
    logic signed [WIDTH-1:0] rem;
    logic                    busy;
    logic                    done;
    logic                    ovf;
    logic                    dbz;

    modport master (
        output start, a, b,
        input  quot, rem, busy, done, ovf, dbz
    );

    modport slave (
        input  start, a, b,
        output quot, rem, busy, done, ovf, dbz
    );
endinterface

// File: rtl/divider.sv
// Signed restoring shift-subtract divider, one quotient bit per clock, start/done handshake.
// Optional macro DIVIDER_EARLY_EXIT_EN: b=0, b=+-1 and |a|<|b| finish on the accepting edge.
module divider #(
    parameter int WIDTH = 8
) (
    input  logic     clk,
    input  logic     rst,
    divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_prem;
    logic             r_sign_q;
    logic             r_sign_r;
    logic             r_ovf_pend;
    logic             r_dbz_pend;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic             r_done;
    logic             r_ovf;
    logic             r_dbz;

    logic             w_accept;
    logic             w_last;
    logic             w_trivial;
    logic             w_sign_q_in;
    logic             w_ovf_in;
    logic             w_dbz_in;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_prem_next;
    logic [WIDTH-1:0] w_dvd_next;
    logic [WIDTH-1:0] w_fix_q;
    logic [WIDTH-1:0] w_fix_r;

    function automatic logic [WIDTH-1:0] apply_sign(input logic neg, input logic [WIDTH-1:0] mag);
        return neg ? -mag : mag;
    endfunction

    // Magnitudes are unsigned WIDTH bits, so |-2^(WIDTH-1)| is representable.
    assign w_a_mag     = bus.a[WIDTH-1] ? -bus.a : bus.a;
    assign w_b_mag     = bus.b[WIDTH-1] ? -bus.b : bus.b;
    assign w_sign_q_in = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
    assign w_dbz_in    = (bus.b == '0);
    assign w_ovf_in    = (bus.a == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.b == '1);
    assign w_accept    = bus.start && (r_state != S_RUN);
    assign w_last      = (r_cnt == CW'(WIDTH - 1));

    // One restoring step; the difference fits WIDTH bits whenever it is kept.
    assign w_shift     = {r_prem, r_dvd[WIDTH-1]};
    assign w_ge        = (w_shift >= {1'b0, r_dvs});
    assign w_diff      = w_shift[WIDTH-1:0] - r_dvs;
    assign w_prem_next = w_ge ? w_diff : w_shift[WIDTH-1:0];
    assign w_dvd_next  = {r_dvd[WIDTH-2:0], w_ge};

    // Zero divisor would yield all-ones magnitude; the remainder already equals |a|.
    assign w_fix_q = r_dbz_pend ? '0 : apply_sign(r_sign_q, w_dvd_next);
    assign w_fix_r = apply_sign(r_sign_r, w_prem_next);

`ifdef DIVIDER_EARLY_EXIT_EN
    logic [WIDTH-1:0] w_triv_quot;
    logic [WIDTH-1:0] w_triv_rem;

    assign w_trivial   = w_dbz_in || (w_b_mag == WIDTH'(1)) || (w_a_mag < w_b_mag);
    assign w_triv_quot = (w_b_mag == WIDTH'(1)) ? apply_sign(w_sign_q_in, w_a_mag) : '0;
    assign w_triv_rem  = (w_b_mag == WIDTH'(1)) ? '0 : bus.a;
`else
    assign w_trivial = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_next = w_trivial ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.start) begin
                    w_state_next = w_trivial ? S_DONE : S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_dvd      <= '0;
            r_dvs      <= '0;
            r_prem     <= '0;
            r_sign_q   <= 1'b0;
            r_sign_r   <= 1'b0;
            r_ovf_pend <= 1'b0;
            r_dbz_pend <= 1'b0;
            r_quot     <= '0;
            r_rem      <= '0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
            r_dbz      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_dvd      <= w_a_mag;
                r_dvs      <= w_b_mag;
                r_prem     <= '0;
                r_cnt      <= '0;
                r_sign_q   <= w_sign_q_in;
                r_sign_r   <= bus.a[WIDTH-1];
                r_ovf_pend <= w_ovf_in;
                r_dbz_pend <= w_dbz_in;
                r_ovf      <= 1'b0;
                r_dbz      <= 1'b0;
`ifdef DIVIDER_EARLY_EXIT_EN
                if (w_trivial) begin
                    r_quot <= w_triv_quot;
                    r_rem  <= w_triv_rem;
                    r_ovf  <= w_ovf_in;
                    r_dbz  <= w_dbz_in;
                    r_done <= 1'b1;
                end
`endif
            end else if (r_state == S_RUN) begin
                r_prem <= w_prem_next;
                r_dvd  <= w_dvd_next;
                r_cnt  <= r_cnt + CW'(1);
                if (w_last) begin
                    r_quot <= w_fix_q;
                    r_rem  <= w_fix_r;
                    r_ovf  <= r_ovf_pend;
                    r_dbz  <= r_dbz_pend;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign bus.quot = r_quot;
    assign bus.rem  = r_rem;
    assign bus.busy = (r_state == S_RUN);
    assign bus.done = r_done;
    assign bus.ovf  = r_ovf;
    assign bus.dbz  = r_dbz;
endmodule

// File: tb/tb_divider.sv
// Directed-vector bench for the signed sequential divider, with hand-computed results.
// Expected latencies follow DIVIDER_EARLY_EXIT_EN when the macro is defined.
module tb_divider;
    localparam int WIDTH = 8;
`ifdef DIVIDER_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif
    localparam int TIMEOUT = 30;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   cyc;

    divider_if #(.WIDTH(WIDTH)) bus ();

    divider #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Directed vectors: a, b, quotient, remainder, ovf, dbz, trivial-case flag
    int va[7]   = '{ 100, -100,  100, -100,  5, -128,  3};
    int vb[7]   = '{   7,    7,   -7,   -7,  0,   -1, 10};
    int vq[7]   = '{  14,  -14,  -14,   14,  0, -128,  0};
    int vr[7]   = '{   2,   -2,    2,   -2,  5,    0,  3};
    int vo[7]   = '{   0,    0,    0,    0,  0,    1,  0};
    int vz[7]   = '{   0,    0,    0,    0,  1,    0,  0};
    int vt[7]   = '{   0,    0,    0,    0,  1,    1,  1};

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Caller must be away from the rising edge; returns 1ns after the accepting edge.
    task automatic start_op(input int a, input int b);
        bus.start = 1'b1;
        bus.a     = 8'(a);
        bus.b     = 8'(b);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int busy_n);
        lat    = 0;
        busy_n = 0;
        while (bus.done !== 1'b1 && lat < TIMEOUT) begin
            if (bus.busy === 1'b1) busy_n++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic check_out(input string tag, input int q, input int r, input int o, input int z);
        check({tag, ".done"}, bus.done, 1);
        check({tag, ".quot"}, bus.quot, q);
        check({tag, ".rem"},  bus.rem,  r);
        check({tag, ".ovf"},  bus.ovf,  o);
        check({tag, ".dbz"},  bus.dbz,  z);
    endtask

    initial begin
        int lat;
        int busy_n;
        int c1;
        int exp_lat;
        string tag;

        n_checks  = 0;
        n_errors  = 0;
        cyc       = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.quot", bus.quot, 0);
        check("reset.rem",  bus.rem,  0);
        check("reset.busy", bus.busy, 0);
        check("reset.done", bus.done, 0);
        check("reset.ovf",  bus.ovf,  0);
        check("reset.dbz",  bus.dbz,  0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            tag = $sformatf("op%0d(%0d/%0d)", i, va[i], vb[i]);
            exp_lat = (EE && vt[i] != 0) ? 0 : WIDTH;
            start_op(va[i], vb[i]);
            wait_done(lat, busy_n);
            check_out(tag, vq[i], vr[i], vo[i], vz[i]);
            check({tag, ".lat"},  lat,    exp_lat);
            check({tag, ".busy"}, busy_n, exp_lat);
            @(posedge clk);
            #1;
            check({tag, ".pulse"}, bus.done, 0);
            repeat (2) @(posedge clk);
            #1;
            check({tag, ".hold"}, bus.quot, vq[i]);
            $display("op %0d: %0d / %0d -> quot %0d rem %0d ovf %0d dbz %0d lat %0d",
                     i, va[i], vb[i], bus.quot, bus.rem, bus.ovf, bus.dbz, lat);
            @(negedge clk);
        end

        // A start during RUN must not re-sample the operands.
        start_op(100, 7);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'(9);
        bus.b     = 8'(3);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(lat, busy_n);
        check_out("ignore", 14, 2, 0, 0);
        check("ignore.lat", lat, WIDTH - 1);
        $display("ignore: quot %0d rem %0d", bus.quot, bus.rem);
        @(negedge clk);

        // Reset four cycles into an operation aborts it with no done pulse.
        start_op(100, 7);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort.quot", bus.quot, 0);
        check("abort.rem",  bus.rem,  0);
        check("abort.busy", bus.busy, 0);
        check("abort.done", bus.done, 0);
        @(negedge clk);
        rst = 1'b0;
        busy_n = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) busy_n++;
        end
        check("abort.idle", busy_n, 0);
        $display("abort: quot %0d rem %0d idle-violations %0d", bus.quot, bus.rem, busy_n);
        @(negedge clk);
        start_op(-128, 2);
        wait_done(lat, busy_n);
        check_out("after_abort", -64, 0, 0, 0);
        check("after_abort.lat", lat, WIDTH);
        $display("after_abort: quot %0d rem %0d lat %0d", bus.quot, bus.rem, lat);
        @(negedge clk);

        // Back-to-back: second start issued in the DONE cycle.
        start_op(127, 1);
        wait_done(lat, busy_n);
        c1 = cyc;
        check_out("b2b_1", 127, 0, 0, 0);
        $display("b2b_1: quot %0d rem %0d lat %0d", bus.quot, bus.rem, lat);
        start_op(-1, 2);
        wait_done(lat, busy_n);
        check_out("b2b_2", 0, -1, 0, 0);
        check("b2b.gap", cyc - c1, EE ? 1 : WIDTH + 1);
        $display("b2b_2: quot %0d rem %0d gap %0d", bus.quot, bus.rem, cyc - c1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
